// File: rtl/imm_field_encoder.sv
// rtl/imm_field_encoder.sv - packs a signed immediate into RV32I I/S/B/J fields, 2-stage valid/ready pipe
// Optional round-trip checker: define IMM_ROUNDTRIP_CHECK_EN to add the rt_mismatch output.
module imm_field_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ImmSrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr,
  output logic             range_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
`ifdef IMM_ROUNDTRIP_CHECK_EN
  ,
  output logic             rt_mismatch
`endif
);

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Only imm[20:0] reaches the packed word; the checker also needs the upper bits.
`ifdef IMM_ROUNDTRIP_CHECK_EN
  localparam int IMM_W = 32;
`else
  localparam int IMM_W = 21;
`endif

  function automatic logic imm_bad(input logic [1:0] src, input logic [31:0] v);
    logic bad;
    case (src)
      SRC_I, SRC_S: bad = !((&v[31:11]) || !(|v[31:11]));
      SRC_B:        bad = !((&v[31:12]) || !(|v[31:12])) || v[0];
      default:      bad = !((&v[31:20]) || !(|v[31:20])) || v[0];
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] pack(input logic [1:0] src, input logic [20:0] v,
                                       input logic [24:0] b);
    logic [31:0] w;
    case (src)
      SRC_I:   w = {v[11:0], b[19:0]};
      SRC_S:   w = {v[11:5], b[24:12], v[4:0], b[6:0]};
      SRC_B:   w = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
      default: w = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
    endcase
    return w;
  endfunction

  logic             en;
  logic             s1_valid;
  logic [1:0]       s1_src;
  logic [IMM_W-1:0] s1_imm;
  logic [24:0]      s1_base;
  logic             s1_err;

  // base_instr[31:25] is immediate field in every format, so it never survives packing.
  logic unused_base_hi;
  assign unused_base_hi = ^base_instr[31:25];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_imm   <= '0;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_src  <= ImmSrc;
        s1_imm  <= imm[IMM_W-1:0];
        s1_base <= base_instr[24:0];
        s1_err  <= imm_bad(ImmSrc, imm);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Instr     <= '0;
      range_err <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Instr     <= pack(s1_src, s1_imm[20:0], s1_base);
        range_err <= s1_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_valid && out_ready) begin
      if (enc_count != '1)
        enc_count <= enc_count + CNT_ONE;
      if (range_err && (err_count != '1))
        err_count <= err_count + CNT_ONE;
    end
  end

`ifdef IMM_ROUNDTRIP_CHECK_EN
  logic [1:0]  s2_src;
  logic [31:0] s2_imm;
  logic [31:0] rt_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_src <= '0;
      s2_imm <= '0;
    end else if (en && s1_valid) begin
      s2_src <= s1_src;
      s2_imm <= s1_imm;
    end
  end

  // Same decode as the sign-extension unit, applied to the word actually being emitted.
  always_comb begin
    rt_dec = '0;
    case (s2_src)
      SRC_I:   rt_dec = {{20{Instr[31]}}, Instr[31:20]};
      SRC_S:   rt_dec = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      SRC_B:   rt_dec = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      default: rt_dec = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
    endcase
  end

  assign rt_mismatch = out_valid && !range_err && (rt_dec != s2_imm);
`endif

endmodule
